ram_access_monitor: RTL and testbench
=====================================

// Module: ram_access_monitor
// PURPOSE
//  Synthesizable, parametrised monitor for N single-port RAM channels in the video datapath (blur/mirror line buffers).
//  Detects multi-write, out-of-range address and same-cycle cross-channel read/write hazards.
//  Counts violations and per-channel accesses, latches first-error details for firmware/bench readout.
//  Sits beside the RAM controller. Taps cs/we/addr only and never drives the RAMs.
// PARAMETERS
//  N_CH        4        number of RAM channels (1..16)
//  AW          16       address width per channel
//  ADDR_LIMIT  'h1000   first illegal address; valid range is addr < ADDR_LIMIT
//  CW          8        width of every counter (saturating)
// PORTS
//  i_CLK           in   1        system clock
//  i_RST           in   1        synchronous, active-low reset
//  i_check_enable  in   1        gates all detection and counting
//  i_clear         in   1        one-cycle pulse: clear capture, sticky flags, all counters
//  i_cs            in   N_CH     chip select per channel
//  i_we            in   N_CH     write enable per channel (valid when cs=1)
//  i_addr          in   N_CH*AW  flattened addresses, channel k at [k*AW +: AW]
//  o_state         out  2        FSM state (ram_mon_pkg::state_e)
//  o_err_valid     out  1        first error captured
//  o_err_type      out  2        captured type: 0 MULTI_WR, 1 ADDR_RANGE, 2 RW_HAZARD
//  o_err_chan      out  4        captured channel index
//  o_err_addr      out  AW       captured address
//  o_err_sticky    out  3        per-type sticky flags, bit = type code
//  o_viol_cnt      out  CW       cycles with >=1 violation
//  o_acc_cnt       out  N_CH*CW  per-channel cs-active cycle count
// BEHAVIOUR
//  Reset (i_RST=0 at posedge): all outputs 0, state IDLE.
//  Detection is combinational on sampled inputs. Results register at the same edge, so outputs reflect a violation 1 cycle later.
//  Detection and counting happen only when i_check_enable=1 and state!=IDLE.
//  MULTI_WR: more than one k with cs[k]&we[k]. Channel = lowest writing k. Addr = its addr.
//  ADDR_RANGE: cs[k] && addr[k] >= ADDR_LIMIT. Channel = lowest such k.
//  RW_HAZARD: cs[i]&we[i] and cs[j]&!we[j], i!=j, addr[i]==addr[j]. Channel = writer i (lowest). Addr = shared address.
//  Several types in one cycle: all sticky bits set. Capture takes the lowest type code.
//  FSM:
//    IDLE -> ARMED on first cycle with i_check_enable=1.
//    ARMED -> CAPTURED on any violation. Latches type/chan/addr and sets o_err_valid.
//    CAPTURED holds its capture. Later violations update only sticky flags and counters.
//    CAPTURED -> ARMED on i_clear.
//  i_check_enable=0 in ARMED/CAPTURED: state and all registers hold.
//  i_clear with a violation in the same cycle: clear first, then capture.
//    Result: state CAPTURED, o_viol_cnt=1, sticky = new types only, acc counts restart at this cycle's accesses.
//  i_clear in IDLE: no effect beyond counters already 0.
//  Counters saturate at 2**CW-1 and never wrap. o_viol_cnt increments at most once per cycle.
//  Reset mid-capture: everything returns to reset values in that edge, including state IDLE.
// CONFIGURATION
//  RAM_MON_SVA_EN defined: concurrent SVA compiled in, all disabled under !i_RST.
//    Each violation type raises $error with channel/address.
//    Consistency checks: o_err_valid == (state==CAPTURED); o_viol_cnt monotonic between clears.
//  RAM_MON_SVA_EN undefined: pure synthesizable RTL with identical port behaviour and no assertions.
// STRUCTURE
//  Package ram_mon_pkg:
//    state_e {IDLE=0, ARMED=1, CAPTURED=2}
//    err_type_e {MULTI_WR=0, ADDR_RANGE=1, RW_HAZARD=2}
//    ERR_TYPES=3
//  Sub-module ram_mon_sat_cnt #(CW): enable, sync clear, saturating increment.
//    Instantiated N_CH+1 times (accesses + violations).
//  Priority encoders and the pairwise address comparators stay in the top module's generate loops.
// TESTING (N_CH=4, AW=16, ADDR_LIMIT='h1000, CW=8)
//  1. Reset, enable, cs=4'b0001 we=0 addr0='h0FFF for 3 cycles
//     -> state ARMED, acc_cnt[0]=3, no error.
//  2. cs=we=4'b0110 addr1=addr2='h0010 one cycle
//     -> next cycle err_valid=1, type=0, chan=1, addr='h0010, sticky=3'b001, viol_cnt=1.
//  3. ARMED, cs[3]=1 addr3='h1000 along with cs0&we0 addr0='h0200 and cs2 read addr2='h0200
//     -> sticky=3'b110, capture type=1, chan=3, addr='h1000.
//  4. In CAPTURED, i_clear plus a new MULTI_WR in the same cycle
//     -> CAPTURED, type=0, viol_cnt=1, sticky=3'b001.
//  5. Hold an illegal addr for 300 cycles -> viol_cnt=255 (saturated, no wrap).
//     Drop i_check_enable -> all outputs frozen.
//  6. Drive i_RST=0 for one edge while CAPTURED -> all outputs 0, state IDLE next cycle.

Source files
------------

// File: rtl/ram_mon_pkg.sv
// ram_mon_pkg: shared types for the RAM access monitor.
//   state_e    : monitor FSM state encoding
//   err_type_e : violation type codes; the code is also the bit index in the sticky flags
//   ERR_TYPES  : number of violation types (width of sticky flag vector)
package ram_mon_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARMED    = 2'd1,
      CAPTURED = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      MULTI_WR   = 2'd0,
      ADDR_RANGE = 2'd1,
      RW_HAZARD  = 2'd2
   } err_type_e;

   localparam int unsigned ERR_TYPES = 3;

endpackage

// File: rtl/ram_mon_sat_cnt.sv
// ram_mon_sat_cnt: saturating up-counter with enable and synchronous clear.
//   i_CLK   : clock
//   i_RST   : synchronous active-low reset
//   i_clear : clear the count; if i_en is also high the count restarts at 1
//   i_en    : increment by one (holds at all-ones)
//   o_cnt   : current count
module ram_mon_sat_cnt #(
   parameter int unsigned CW = 8
) (
   input  logic          i_CLK,
   input  logic          i_RST,
   input  logic          i_clear,
   input  logic          i_en,
   output logic [CW-1:0] o_cnt
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clear) begin
         // Clear happens before this cycle's event is counted.
         cnt_d = i_en ? CW'(1) : '0;
      end else if (i_en && (cnt_q != '1)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge i_CLK) begin
      if (!i_RST) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign o_cnt = cnt_q;

endmodule

// File: rtl/ram_access_monitor.sv
// ram_access_monitor: passive monitor for N_CH single-port RAM channels.
// Detects multi-write, out-of-range address and same-cycle read/write hazards,
// counts violation cycles and per-channel accesses, latches the first error.
// Optional macro RAM_MON_SVA_EN compiles in concurrent assertions.
// Ports:
//   i_CLK, i_RST (sync, active-low), i_check_enable, i_clear
//   i_cs, i_we [N_CH], i_addr [N_CH*AW] (channel k at [k*AW +: AW])
//   o_state, o_err_valid, o_err_type, o_err_chan, o_err_addr, o_err_sticky
//   o_viol_cnt [CW], o_acc_cnt [N_CH*CW] (channel k at [k*CW +: CW])
module ram_access_monitor
   import ram_mon_pkg::*;
#(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned AW         = 16,
   parameter int unsigned ADDR_LIMIT = 'h1000,
   parameter int unsigned CW         = 8
) (
   input  logic                 i_CLK,
   input  logic                 i_RST,
   input  logic                 i_check_enable,
   input  logic                 i_clear,
   input  logic [N_CH-1:0]      i_cs,
   input  logic [N_CH-1:0]      i_we,
   input  logic [N_CH*AW-1:0]   i_addr,
   output logic [1:0]           o_state,
   output logic                 o_err_valid,
   output logic [1:0]           o_err_type,
   output logic [3:0]           o_err_chan,
   output logic [AW-1:0]        o_err_addr,
   output logic [ERR_TYPES-1:0] o_err_sticky,
   output logic [CW-1:0]        o_viol_cnt,
   output logic [N_CH*CW-1:0]   o_acc_cnt
);

   logic [N_CH-1:0] wr, rd, rng_hit, haz_wr;
   logic [AW-1:0]   ch_addr [N_CH];

   assign wr = i_cs & i_we;
   assign rd = i_cs & ~i_we;

   // Per-channel range check and pairwise writer/reader address comparators.
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [N_CH-1:0] pair_hit;
      assign ch_addr[i] = i_addr[i*AW +: AW];
      assign rng_hit[i] = i_cs[i] && (32'(ch_addr[i]) >= ADDR_LIMIT);
      for (genvar j = 0; j < N_CH; j++) begin : g_pair
         if (i == j) begin : g_self
            assign pair_hit[j] = 1'b0;
         end else begin : g_other
            assign pair_hit[j] = rd[j] && (i_addr[i*AW +: AW] == i_addr[j*AW +: AW]);
         end
      end
      assign haz_wr[i] = wr[i] && (|pair_hit);
   end

   // Lowest-index priority encoders for each violation type.
   logic          multi, seen_wr, rng_any, haz_any;
   logic [3:0]    mw_chan, rng_chan, haz_chan;
   logic [AW-1:0] mw_addr, rng_addr, haz_addr;

   always_comb begin
      multi    = 1'b0;
      seen_wr  = 1'b0;
      mw_chan  = '0;
      mw_addr  = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (wr[k]) begin
            if (seen_wr) begin
               multi = 1'b1;
            end else begin
               seen_wr = 1'b1;
               mw_chan = 4'(k);
               mw_addr = ch_addr[k];
            end
         end
      end
      rng_any  = 1'b0;
      rng_chan = '0;
      rng_addr = '0;
      haz_any  = 1'b0;
      haz_chan = '0;
      haz_addr = '0;
      // Descending scan so the lowest index wins.
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (rng_hit[k]) begin
            rng_any  = 1'b1;
            rng_chan = 4'(k);
            rng_addr = ch_addr[k];
         end
         if (haz_wr[k]) begin
            haz_any  = 1'b1;
            haz_chan = 4'(k);
            haz_addr = ch_addr[k];
         end
      end
   end

   logic [ERR_TYPES-1:0] viol_types;
   logic                 any_viol, active;

   assign viol_types = {haz_any, rng_any, multi};
   assign any_viol   = |viol_types;

   // State and capture registers
   state_e               state_q, state_d;
   logic                 valid_q, valid_d;
   err_type_e            type_q, type_d;
   logic [3:0]           chan_q, chan_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [ERR_TYPES-1:0] sticky_q, sticky_d;

   assign active = i_check_enable && (state_q != IDLE);

   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      type_d   = type_q;
      chan_d   = chan_q;
      addr_d   = addr_q;
      sticky_d = sticky_q;
      case (state_q)
         IDLE: begin
            if (i_check_enable) state_d = ARMED;
         end
         default: begin
            if (i_check_enable) begin
               // Clear first, so a same-cycle violation is captured afresh.
               if (i_clear) begin
                  state_d  = ARMED;
                  valid_d  = 1'b0;
                  type_d   = MULTI_WR;
                  chan_d   = '0;
                  addr_d   = '0;
                  sticky_d = '0;
               end
               sticky_d = sticky_d | viol_types;
               if (any_viol && (state_d == ARMED)) begin
                  state_d = CAPTURED;
                  valid_d = 1'b1;
                  if (multi) begin
                     type_d = MULTI_WR;
                     chan_d = mw_chan;
                     addr_d = mw_addr;
                  end else if (rng_any) begin
                     type_d = ADDR_RANGE;
                     chan_d = rng_chan;
                     addr_d = rng_addr;
                  end else begin
                     type_d = RW_HAZARD;
                     chan_d = haz_chan;
                     addr_d = haz_addr;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_CLK) begin
      if (!i_RST) begin
         state_q  <= IDLE;
         valid_q  <= 1'b0;
         type_q   <= MULTI_WR;
         chan_q   <= '0;
         addr_q   <= '0;
         sticky_q <= '0;
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         type_q   <= type_d;
         chan_q   <= chan_d;
         addr_q   <= addr_d;
         sticky_q <= sticky_d;
      end
   end

   ram_mon_sat_cnt #(.CW(CW)) u_viol_cnt (
      .i_CLK   (i_CLK),
      .i_RST   (i_RST),
      .i_clear (active && i_clear),
      .i_en    (active && any_viol),
      .o_cnt   (o_viol_cnt)
   );

   for (genvar k = 0; k < N_CH; k++) begin : g_acc
      ram_mon_sat_cnt #(.CW(CW)) u_acc_cnt (
         .i_CLK   (i_CLK),
         .i_RST   (i_RST),
         .i_clear (active && i_clear),
         .i_en    (active && i_cs[k]),
         .o_cnt   (o_acc_cnt[k*CW +: CW])
      );
   end

   assign o_state      = state_q;
   assign o_err_valid  = valid_q;
   assign o_err_type   = type_q;
   assign o_err_chan   = chan_q;
   assign o_err_addr   = addr_q;
   assign o_err_sticky = sticky_q;

`ifdef RAM_MON_SVA_EN
   a_multi_wr: assert property (@(posedge i_CLK) disable iff (!i_RST) !(active && multi))
      else $error("MULTI_WR chan %0d addr %h", mw_chan, mw_addr);
   a_addr_range: assert property (@(posedge i_CLK) disable iff (!i_RST) !(active && rng_any))
      else $error("ADDR_RANGE chan %0d addr %h", rng_chan, rng_addr);
   a_rw_hazard: assert property (@(posedge i_CLK) disable iff (!i_RST) !(active && haz_any))
      else $error("RW_HAZARD chan %0d addr %h", haz_chan, haz_addr);
   a_valid_state: assert property (@(posedge i_CLK) disable iff (!i_RST)
      o_err_valid == (state_q == CAPTURED));
   a_viol_mono: assert property (@(posedge i_CLK) disable iff (!i_RST)
      !$past(active && i_clear) |-> (o_viol_cnt >= $past(o_viol_cnt)));
`else
   // Assertions compiled out; port behaviour is unchanged.
`endif

endmodule

// File: tb/tb_ram_access_monitor.sv
// tb_ram_access_monitor: table-driven check of ram_access_monitor (N_CH=4, AW=16, CW=8).
// Each step drives one cycle of inputs, queues the expected post-edge outputs,
// then pops and compares shortly after the clock edge.
module tb_ram_access_monitor;

   typedef struct packed {
      logic        rst;
      logic        en;
      logic        clr;
      logic [3:0]  cs;
      logic [3:0]  we;
      logic [63:0] addr;
   } stim_t;

   typedef struct packed {
      logic [1:0]  st;
      logic        vld;
      logic [1:0]  typ;
      logic [3:0]  chan;
      logic [15:0] addr;
      logic [2:0]  sticky;
      logic [7:0]  viol;
      logic [31:0] acc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        check_enable;
   logic        clear;
   logic [3:0]  cs;
   logic [3:0]  we;
   logic [63:0] addr;
   logic [1:0]  state;
   logic        err_valid;
   logic [1:0]  err_type;
   logic [3:0]  err_chan;
   logic [15:0] err_addr;
   logic [2:0]  err_sticky;
   logic [7:0]  viol_cnt;
   logic [31:0] acc_cnt;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   ram_access_monitor #(
      .N_CH       (4),
      .AW         (16),
      .ADDR_LIMIT ('h1000),
      .CW         (8)
   ) dut (
      .i_CLK          (clk),
      .i_RST          (rst_n),
      .i_check_enable (check_enable),
      .i_clear        (clear),
      .i_cs           (cs),
      .i_we           (we),
      .i_addr         (addr),
      .o_state        (state),
      .o_err_valid    (err_valid),
      .o_err_type     (err_type),
      .o_err_chan     (err_chan),
      .o_err_addr     (err_addr),
      .o_err_sticky   (err_sticky),
      .o_viol_cnt     (viol_cnt),
      .o_acc_cnt      (acc_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t mk_stim(logic r, logic e, logic c, logic [3:0] s, logic [3:0] w,
                                     logic [15:0] a3, logic [15:0] a2, logic [15:0] a1,
                                     logic [15:0] a0);
      stim_t t;
      t.rst  = r;
      t.en   = e;
      t.clr  = c;
      t.cs   = s;
      t.we   = w;
      t.addr = {a3, a2, a1, a0};
      return t;
   endfunction

   function automatic exp_t mk_exp(logic [1:0] st, logic v, logic [1:0] ty, logic [3:0] ch,
                                   logic [15:0] ad, logic [2:0] sk, logic [7:0] vc,
                                   logic [7:0] c3, logic [7:0] c2, logic [7:0] c1,
                                   logic [7:0] c0);
      exp_t x;
      x.st     = st;
      x.vld    = v;
      x.typ    = ty;
      x.chan   = ch;
      x.addr   = ad;
      x.sticky = sk;
      x.viol   = vc;
      x.acc    = {c3, c2, c1, c0};
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, req);
      end
   endtask

   task automatic check_out(input string tag);
      exp_t x;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard empty got 0 expected 1", tag);
         return;
      end
      x = sb_q.pop_front();
      chk({tag, ".state"},  32'(state),      32'(x.st));
      chk({tag, ".valid"},  32'(err_valid),  32'(x.vld));
      chk({tag, ".type"},   32'(err_type),   32'(x.typ));
      chk({tag, ".chan"},   32'(err_chan),   32'(x.chan));
      chk({tag, ".addr"},   32'(err_addr),   32'(x.addr));
      chk({tag, ".sticky"}, 32'(err_sticky), 32'(x.sticky));
      chk({tag, ".viol"},   32'(viol_cnt),   32'(x.viol));
      chk({tag, ".acc"},    acc_cnt,         x.acc);
   endtask

   task automatic step(input stim_t s, input exp_t x, input string tag);
      rst_n        = s.rst;
      check_enable = s.en;
      clear        = s.clr;
      cs           = s.cs;
      we           = s.we;
      addr         = s.addr;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      check_out(tag);
   endtask

   localparam int NV = 17;
   stim_t vs[NV];
   exp_t  ve[NV];

   initial begin
      exp_t  x;
      stim_t s;
      // Reset, then enable with no traffic (IDLE -> ARMED, nothing counted)
      vs[0]  = mk_stim(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
      ve[0]  = mk_exp(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
      vs[1]  = mk_stim(1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
      ve[1]  = mk_exp(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
      // Legal reads at the last valid address
      vs[2]  = mk_stim(1, 1, 0, 4'b0001, 4'b0000, 0, 0, 0, 'h0FFF);
      ve[2]  = mk_exp(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1);
      vs[3]  = vs[2];
      ve[3]  = mk_exp(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2);
      vs[4]  = vs[2];
      ve[4]  = mk_exp(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 3);
      // Two writers: MULTI_WR on channel 1
      vs[5]  = mk_stim(1, 1, 0, 4'b0110, 4'b0110, 0, 'h0010, 'h0010, 'h0FFF);
      ve[5]  = mk_exp(2, 1, 0, 1, 'h0010, 3'b001, 1, 0, 1, 1, 3);
      // Clear without violation
      vs[6]  = mk_stim(1, 1, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
      ve[6]  = mk_exp(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
      // Range on ch3 plus hazard ch0 write / ch2 read; range wins capture
      vs[7]  = mk_stim(1, 1, 0, 4'b1101, 4'b0001, 'h1000, 'h0200, 0, 'h0200);
      ve[7]  = mk_exp(2, 1, 1, 3, 'h1000, 3'b110, 1, 1, 1, 0, 1);
      // Later violation in CAPTURED: sticky and counters only
      vs[8]  = mk_stim(1, 1, 0, 4'b0011, 4'b0011, 0, 0, 'h0006, 'h0005);
      ve[8]  = mk_exp(2, 1, 1, 3, 'h1000, 3'b111, 2, 1, 1, 1, 2);
      // Clear with same-cycle MULTI_WR
      vs[9]  = mk_stim(1, 1, 1, 4'b1100, 4'b1100, 'h0008, 'h0007, 0, 0);
      ve[9]  = mk_exp(2, 1, 0, 2, 'h0007, 3'b001, 1, 1, 1, 0, 0);
      // Enable low: everything holds, clear ignored
      vs[10] = mk_stim(1, 0, 0, 4'b1111, 4'b1111, 'h2000, 'h2000, 'h2000, 'h2000);
      ve[10] = ve[9];
      vs[11] = mk_stim(1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
      ve[11] = ve[9];
      vs[12] = mk_stim(1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
      ve[12] = ve[9];
      // Reset mid-capture
      vs[13] = mk_stim(0, 1, 0, 4'b1111, 4'b1111, 'h2000, 'h2000, 'h2000, 'h2000);
      ve[13] = mk_exp(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
      // First enabled cycle in IDLE does not detect
      vs[14] = mk_stim(1, 1, 0, 4'b0001, 4'b0001, 0, 0, 0, 'hFFFF);
      ve[14] = mk_exp(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
      vs[15] = vs[14];
      ve[15] = mk_exp(2, 1, 1, 0, 'hFFFF, 3'b010, 1, 0, 0, 0, 1);
      // Clear plus pure RW hazard: writer ch1, reader ch0
      vs[16] = mk_stim(1, 1, 1, 4'b0011, 4'b0010, 0, 0, 'h0123, 'h0123);
      ve[16] = mk_exp(2, 1, 2, 1, 'h0123, 3'b100, 1, 0, 0, 1, 1);

      for (int i = 0; i < NV; i++) begin
         step(vs[i], ve[i], $sformatf("vec%0d", i));
      end

      // Saturation: clear, then hold an illegal read on ch3 for 300 cycles
      s = mk_stim(1, 1, 1, 4'b1000, 4'b0000, 'h1000, 0, 0, 0);
      x = mk_exp(2, 1, 1, 3, 'h1000, 3'b010, 1, 1, 0, 0, 0);
      step(s, x, "sat1");
      s.clr = 1'b0;
      for (int i = 2; i <= 300; i++) begin
         logic [7:0] c;
         c = (i > 255) ? 8'd255 : 8'(i);
         x = mk_exp(2, 1, 1, 3, 'h1000, 3'b010, c, c, 0, 0, 0);
         step(s, x, $sformatf("sat%0d", i));
      end

      // Enable low after saturation: all outputs frozen
      s = mk_stim(1, 0, 1, 4'b1111, 4'b1111, 'h3000, 'h3000, 'h3000, 'h3000);
      for (int i = 0; i < 3; i++) begin
         step(s, x, $sformatf("freeze%0d", i));
      end

      // Reset while captured, then clear in IDLE has no effect
      s = mk_stim(0, 1, 0, 4'b1000, 4'b0000, 'h1000, 0, 0, 0);
      x = mk_exp(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
      step(s, x, "rst_cap");
      s = mk_stim(1, 0, 1, 4'b1111, 4'b1111, 'h1000, 'h1000, 'h1000, 'h1000);
      step(s, x, "idle_clr");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
